// File: rtl/mssd_pkg.sv
// Shared definitions for the MSSD serial data path: controller state encoding
// and the widths shared between the transmit controller and its word counter.
package mssd_pkg;

   localparam int DEF_WORD_W = 8;
   localparam int CNT_W      = 5;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_CHECK = 3'd2,
      ST_FETCH = 3'd3,
      ST_SHIFT = 3'd4,
      ST_DEC   = 3'd5,
      ST_DONE  = 3'd6
   } tx_state_t;

endpackage

// File: rtl/mssd_tx_shreg.sv
// Parallel-load, left-shift register for one transmit word, with a bit counter
// that flags the final bit so the controller knows when the word is exhausted.
module mssd_tx_shreg #(
   parameter int WORD_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              shift,
   input  logic [WORD_W-1:0] din,
   output logic              msb,
   output logic              last_bit
);

   localparam int BIT_W = (WORD_W > 2) ? $clog2(WORD_W) : 1;
   localparam logic [BIT_W-1:0] LAST_IDX = BIT_W'(WORD_W - 1);

   logic [WORD_W-1:0] shreg;
   logic [BIT_W-1:0]  bit_cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         shreg   <= '0;
         bit_cnt <= '0;
      end else if (load) begin
         shreg   <= din;
         bit_cnt <= '0;
      end else if (shift) begin
         shreg   <= {shreg[WORD_W-2:0], 1'b0};
         // Counter stops at the last index; the controller leaves SHIFT there.
         if (bit_cnt != LAST_IDX) begin
            bit_cnt <= bit_cnt + 1'b1;
         end
      end
   end

   assign msb      = shreg[WORD_W-1];
   assign last_bit = (bit_cnt == LAST_IDX);

endmodule

// File: rtl/mssd_tx_ctrl.sv
// Transmit controller: fetches data_num words from a source and serializes each
// MSB-first, driving load/decrement strobes of the downstream word counter.
module mssd_tx_ctrl
   import mssd_pkg::*;
#(
   parameter int WORD_W = DEF_WORD_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [CNT_W-1:0]  data_num,
   input  logic [WORD_W-1:0] word_in,
   input  logic              word_valid,
   output logic              word_ready,
   input  logic              abort,
   input  logic              co_d,
   output logic              ld_cnt_d,
   output logic              cnt_d,
   output logic [CNT_W-1:0]  data_num_out,
   output logic              sdo,
   output logic              sdo_valid,
   output logic              busy,
   output logic              done,
   output logic              aborted,
   output tx_state_t         state_dbg
);

   // Source handshake: a word transfers on a rising edge where word_valid and
   // word_ready are both 1; word_ready depends only on state (FETCH), never on
   // word_valid, and the source must hold word_in stable while word_valid is 1.

   tx_state_t state, next_state;
   logic      cancel;
   logic      aborted_q;
   logic      shreg_load;
   logic      shreg_shift;
   logic      shreg_msb;
   logic      last_bit;

   assign cancel = abort && (state != ST_IDLE) && (state != ST_DONE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE:  if (start) next_state = ST_LOAD;
         ST_LOAD:  next_state = ST_CHECK;
         ST_CHECK: next_state = co_d ? ST_DONE : ST_FETCH;
         ST_FETCH: if (word_valid) next_state = ST_SHIFT;
         ST_SHIFT: if (last_bit) next_state = ST_DEC;
         ST_DEC:   next_state = ST_CHECK;
         ST_DONE:  next_state = ST_IDLE;
         default:  next_state = ST_IDLE;
      endcase
      if (cancel) begin
         next_state = ST_IDLE;
      end
   end

   always_comb begin
      word_ready = 1'b0;
      ld_cnt_d   = 1'b0;
      cnt_d      = 1'b0;
      sdo        = 1'b0;
      sdo_valid  = 1'b0;
      done       = 1'b0;
      busy       = (state != ST_IDLE);
      case (state)
         ST_LOAD:  ld_cnt_d   = 1'b1;
         ST_FETCH: word_ready = 1'b1;
         ST_SHIFT: begin
            sdo       = shreg_msb;
            sdo_valid = 1'b1;
         end
         ST_DEC:   cnt_d      = 1'b1;
         ST_DONE:  done       = 1'b1;
         default:  ;
      endcase
   end

   // The cancel pulse is registered so it appears in the first IDLE cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         aborted_q    <= 1'b0;
         data_num_out <= '0;
      end else begin
         aborted_q <= cancel;
         if ((state == ST_IDLE) && start) begin
            data_num_out <= data_num;
         end
      end
   end

   assign aborted     = aborted_q;
   assign state_dbg   = state;
   assign shreg_load  = (state == ST_FETCH) && word_valid && !abort;
   assign shreg_shift = (state == ST_SHIFT);

   mssd_tx_shreg #(
      .WORD_W (WORD_W)
   ) u_shreg (
      .clk      (clk),
      .rst      (rst),
      .load     (shreg_load),
      .shift    (shreg_shift),
      .din      (word_in),
      .msb      (shreg_msb),
      .last_bit (last_bit)
   );

endmodule

// File: tb/tb_mssd_tx_ctrl.sv
// Scoreboard bench for mssd_tx_ctrl with a behavioural word counter and source.
module tb_mssd_tx_ctrl;
   import mssd_pkg::*;

   localparam int W = 8;

   logic            clk = 1'b0;
   logic            rst;
   logic            start;
   logic [4:0]      data_num;
   logic [W-1:0]    word_in;
   logic            word_valid;
   logic            word_ready;
   logic            abort;
   logic            co_d;
   logic            ld_cnt_d;
   logic            cnt_d;
   logic [4:0]      data_num_out;
   logic            sdo;
   logic            sdo_valid;
   logic            busy;
   logic            done;
   logic            aborted;
   tx_state_t       state_dbg;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   logic [0:0]   exp_q[$];
   int           done_q[$];
   int           abort_q[$];
   logic [W-1:0] src_q[$];
   logic         src_en;
   logic         src_has = 1'b0;
   logic [W-1:0] src_word = '0;
   logic         take = 1'b0;
   logic [4:0]   wcnt;

   int ld_n = 0, cnt_n = 0, stall_n = 0, sv_n = 0, overlap_n = 0, glitch_n = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mssd_tx_ctrl #(.WORD_W(W)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .data_num     (data_num),
      .word_in      (word_in),
      .word_valid   (word_valid),
      .word_ready   (word_ready),
      .abort        (abort),
      .co_d         (co_d),
      .ld_cnt_d     (ld_cnt_d),
      .cnt_d        (cnt_d),
      .data_num_out (data_num_out),
      .sdo          (sdo),
      .sdo_valid    (sdo_valid),
      .busy         (busy),
      .done         (done),
      .aborted      (aborted),
      .state_dbg    (state_dbg)
   );

   // Word counter placed downstream of the controller.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)          wcnt <= '0;
      else if (ld_cnt_d) wcnt <= data_num_out;
      else if (cnt_d)    wcnt <= wcnt - 5'd1;
   end
   assign co_d = (wcnt == 5'd0);

   // Source: presents the head of src_q, pops it after an accepted transfer.
   assign word_valid = src_en && src_has;
   assign word_in    = src_word;
   always @(negedge clk) take <= word_valid && word_ready;
   always @(posedge clk) begin
      #1;
      if (take && src_q.size() > 0) void'(src_q.pop_front());
      src_has  = (src_q.size() > 0);
      src_word = (src_q.size() > 0) ? src_q[0] : '0;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: pops expected serial bits and event times when the DUT presents them.
   always @(negedge clk) begin
      if (rst) begin
         if (sdo_valid) begin
            if (exp_q.size() == 0) check("sdo_unexpected", 1, 0);
            else check("sdo_bit", {31'd0, sdo}, {31'd0, exp_q.pop_front()});
         end
         if (done) begin
            if (done_q.size() == 0) check("done_unexpected", 1, 0);
            else check("done_cycle", cyc, done_q.pop_front());
         end
         if (aborted) begin
            if (abort_q.size() == 0) check("aborted_unexpected", 1, 0);
            else check("aborted_cycle", cyc, abort_q.pop_front());
         end
         if (ld_cnt_d) ld_n++;
         if (cnt_d) cnt_n++;
         if (word_ready && !word_valid) stall_n++;
         if (sdo_valid) sv_n++;
         if (ld_cnt_d && cnt_d) overlap_n++;
         if (sdo && !sdo_valid) glitch_n++;
      end
   end

   task automatic push_word(input logic [W-1:0] w, input int nbits, input bit to_src);
      if (to_src) src_q.push_back(w);
      for (int i = 0; i < nbits; i++) exp_q.push_back(w[W-1-i]);
   endtask

   task automatic do_start(input logic [4:0] n, output int t0);
      @(posedge clk); #1;
      data_num = n;
      start    = 1'b1;
      t0       = cyc;
      @(posedge clk); #1;
      start    = 1'b0;
   endtask

   task automatic wait_idle(input int max_cyc, input string name);
      int k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (busy && k < max_cyc);
      check(name, {31'd0, busy}, 0);
   endtask

   task automatic check_all_zero(input string name);
      check(name, {23'd0, word_ready, ld_cnt_d, cnt_d, sdo, sdo_valid, busy, done, aborted, 1'b0},
            32'd0);
      check({name, "_dnum"}, {27'd0, data_num_out}, 0);
   endtask

   initial begin
      int t0;
      int ld0, cnt0, stall0, sv0;
      rst = 1'b0; start = 1'b0; abort = 1'b0; data_num = '0; src_en = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset");
      check("reset_state", {29'd0, state_dbg}, {29'd0, ST_IDLE});
      rst = 1'b1;

      // Two words, source always valid.
      ld0 = ld_n; cnt0 = cnt_n;
      push_word(8'hA5, W, 1);
      push_word(8'h3C, W, 1);
      do_start(5'd2, t0);
      done_q.push_back(t0 + 25);
      wait_idle(100, "t1_timeout");
      check("t1_cnt_pulses", cnt_n - cnt0, 2);
      check("t1_ld_pulses", ld_n - ld0, 1);
      check("t1_dnum", {27'd0, data_num_out}, 2);

      // Zero words: straight to DONE.
      ld0 = ld_n; cnt0 = cnt_n; stall0 = stall_n; sv0 = sv_n;
      do_start(5'd0, t0);
      done_q.push_back(t0 + 3);
      wait_idle(20, "t2_timeout");
      check("t2_ld_pulses", ld_n - ld0, 1);
      check("t2_cnt_pulses", cnt_n - cnt0, 0);
      check("t2_sdo_valid_cycles", sv_n - sv0, 0);
      check("t2_ready_cycles", stall_n - stall0, 0);

      // Source stalls for 10 FETCH cycles.
      src_en = 1'b0;
      stall0 = stall_n;
      push_word(8'h96, W, 1);
      do_start(5'd1, t0);
      done_q.push_back(t0 + 24);
      repeat (12) @(posedge clk);
      #1 src_en = 1'b1;
      wait_idle(60, "t3_timeout");
      check("t3_stall_cycles", stall_n - stall0, 10);

      // Restart attempt while busy is ignored.
      cnt0 = cnt_n; ld0 = ld_n;
      push_word(8'h01, W, 1);
      push_word(8'hFE, W, 1);
      push_word(8'h5A, W, 1);
      do_start(5'd3, t0);
      done_q.push_back(t0 + 36);
      repeat (8) @(posedge clk);
      #1 data_num = 5'd7; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      check("t4_dnum_mid", {27'd0, data_num_out}, 3);
      wait_idle(100, "t4_timeout");
      check("t4_dnum_end", {27'd0, data_num_out}, 3);
      check("t4_cnt_pulses", cnt_n - cnt0, 3);
      check("t4_ld_pulses", ld_n - ld0, 1);

      // Abort during the 4th SHIFT cycle, then a clean transfer.
      push_word(8'hC3, 4, 1);
      do_start(5'd2, t0);
      abort_q.push_back(t0 + 8);
      repeat (6) @(posedge clk);
      #1 abort = 1'b1;
      @(posedge clk);
      #1 abort = 1'b0;
      check("t5_busy_after_abort", {31'd0, busy}, 0);
      repeat (4) @(posedge clk);
      push_word(8'h7E, W, 1);
      do_start(5'd1, t0);
      done_q.push_back(t0 + 14);
      wait_idle(40, "t5_timeout");

      // Reset asserted in DEC.
      push_word(8'h81, W, 1);
      do_start(5'd1, t0);
      repeat (11) @(posedge clk);
      #1 check("t6_in_dec", {31'd0, cnt_d}, 1);
      rst = 1'b0;
      #1 check_all_zero("t6_reset");
      check("t6_state", {29'd0, state_dbg}, {29'd0, ST_IDLE});
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      repeat (5) begin
         @(negedge clk);
         check("t6_busy_after_rst", {31'd0, busy}, 0);
      end

      check("left_bits", exp_q.size(), 0);
      check("left_done", done_q.size(), 0);
      check("left_aborted", abort_q.size(), 0);
      check("strobe_overlap", overlap_n, 0);
      check("sdo_outside_valid", glitch_n, 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
